div4_seq: RTL and testbench
===========================

# div4_seq

Sequential 4-bit unsigned restoring divider: accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, and returns quotient and remainder with a one-cycle done pulse. It is the inverse-arithmetic companion to the `cla4` adder and reuses one `cla4` instance as its trial-subtract datapath. It sits as a multi-cycle arithmetic unit under a simple controller that issues start and waits for done.

## Interface
- Parameters: none. Width is fixed at 4 bits to match `cla4`.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `dividend` input 4: unsigned dividend; sampled with accepted start.
- `divisor` input 4: unsigned divisor; sampled with accepted start.
- `busy` output 1: high while an operation is in RUN.
- `done` output 1: one-cycle pulse; results valid and updated.
- `quotient` output 4: registered quotient; holds until next completion.
- `remainder` output 4: registered remainder; holds until next completion.
- `div_by_zero` output 1: registered; set with a completion whose divisor was 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 → load A=0 (4b), Q=`dividend`, M=`divisor`, cnt=0, capture dz=(`divisor`==0); go RUN. `start`=0 → stay.
- RUN, each edge: form shifted partial remainder {hi, T} = {A, Q[3]} (hi = A[3], T = {A[2:0],Q[3]}). Trial subtract via `cla4`: a=T, b=~M, cin=1 → sum D, cout C. Quotient bit qb = hi | C. If qb: A←D, else A←T. Q←{Q[2:0], qb}. cnt←cnt+1.
- After the 4th RUN edge (cnt 3→wrap): latch `quotient`←new Q, `remainder`←new A, `div_by_zero`←dz; go DONE.
- DONE (one cycle, `done`=1): `start`=1 → accept new operation exactly as from IDLE (back-to-back). `start`=0 → IDLE.
- `start` in RUN is ignored, with no queuing. `dividend`/`divisor` changes during RUN have no effect.
- Divisor 0 runs the normal 4 iterations. The algorithm naturally yields `quotient`=4'hF and `remainder`=`dividend`. `div_by_zero`=1 flags it.
- `div_by_zero` holds with results and is overwritten at the next completion.
- `rst` (any state, including mid-RUN): state→IDLE, cnt→0, A/Q/M→0. All outputs→0. An in-flight operation is discarded and produces no `done`.

## Timing
- Accepted start at edge E0. RUN edges E1–E4. `done`, `quotient`, `remainder`, and `div_by_zero` update at E4 and are visible in the cycle after E4.
- Latency: 4 clocks from accepting edge to results; `done` high for exactly one cycle.
- `busy` high from the cycle after E0 through the cycle ending at E4; low in IDLE and DONE.
- Back-to-back: start held high gives a new acceptance at the DONE edge (E5). Throughput is one result per 5 cycles.
- Outputs are registered. The `cla4` path is the only combinational stage per cycle.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and `DIV_W`=4 with the 2-bit counter width. Both are shared with future sequential arithmetic blocks.
- One sub-module: the existing `cla4`, instantiated once as the trial subtractor. There is no separate shift/control sub-module.

## Test plan
- 13/3: start pulse, then exactly 4 cycles later `done`=1 with `quotient`=4, `remainder`=1, `div_by_zero`=0; `busy` high for 4 cycles.
- Corners: 15/1 → 15 r0; 15/15 → 1 r0; 0/5 → 0 r0; 4/9 → 0 r4; 14/7 → 2 r0.
- 7/0 → `quotient`=15, `remainder`=7, `div_by_zero`=1. A following 6/4 clears the flag: 1 r2, `div_by_zero`=0.
- Start 9/2, then pulse start with 15/1 during RUN → single `done` with 4 r1; 15/1 ignored.
- Start held high continuously with 12/5 → `done` every 5 cycles with 2 r2; `busy` low only in DONE cycles.
- `rst` asserted in 2nd RUN cycle of 11/3 → next cycle all outputs 0, IDLE, no `done`. Subsequent 11/3 → 3 r2.

Source files
------------

// File: rtl/div4_seq_pkg.sv
// Shared definitions for the sequential arithmetic blocks: datapath width,
// iteration counter width and controller state encoding.
package div4_seq_pkg;

    localparam int DIV_W = 4;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder; used by div4_seq as its trial subtractor.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    // generate/propagate terms and flattened lookahead carries
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        sum    = p_s ^ c_s[3:0];
        cout   = c_s[4];
    end

endmodule

// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// registered quotient/remainder and a one-cycle done pulse.
module div4_seq
    import div4_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_r, next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [DIV_W-1:0] a_r, q_r, m_r;
    logic             dz_r;
    logic             busy_r, done_r, div_by_zero_r;
    logic [DIV_W-1:0] quotient_r, remainder_r;

    logic             hi_s, c_s, qb_s;
    logic [DIV_W-1:0] t_s, d_s, a_nxt_s, q_nxt_s;

    // trial subtraction T - M as T + ~M + 1; carry out means no borrow
    cla4 u_sub (
        .a    (t_s),
        .b    (~m_r),
        .cin  (1'b1),
        .sum  (d_s),
        .cout (c_s)
    );

    // one restoring step; hi covers the 5th bit of the shifted remainder
    always_comb begin
        hi_s    = a_r[3];
        t_s     = {a_r[2:0], q_r[3]};
        qb_s    = hi_s | c_s;
        if (qb_s) begin
            a_nxt_s = d_s;
        end else begin
            a_nxt_s = t_s;
        end
        q_nxt_s = {q_r[2:0], qb_s};
    end

    // controller next-state
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = RUN;
                else       next_s = IDLE;
            end
            RUN: begin
                if (cnt_r == 2'd3) next_s = DONE;
                else               next_s = RUN;
            end
            DONE: begin
                if (start) next_s = RUN;
                else       next_s = IDLE;
            end
            default: next_s = IDLE;
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 2'd0;
            a_r           <= 4'd0;
            q_r           <= 4'd0;
            m_r           <= 4'd0;
            dz_r          <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= 4'd0;
            remainder_r   <= 4'd0;
            div_by_zero_r <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s == RUN);
            done_r  <= (state_r == RUN) && (cnt_r == 2'd3);
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        a_r   <= 4'd0;
                        q_r   <= dividend;
                        m_r   <= divisor;
                        cnt_r <= 2'd0;
                        dz_r  <= (divisor == 4'd0);
                    end
                end
                RUN: begin
                    a_r   <= a_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        quotient_r    <= q_nxt_s;
                        remainder_r   <= a_nxt_s;
                        div_by_zero_r <= dz_r;
                    end
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq: directed corners plus random operands
// compared against plain integer division.
module tb_div4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int cmp_cnt = 0;
    int err_cnt = 0;

    div4_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // expected {div_by_zero, quotient, remainder}
    function automatic logic [8:0] ref_div(input int dvd, input int dvs);
        int q;
        int r;
        if (dvs == 0) begin
            return {1'b1, 4'hF, dvd[3:0]};
        end
        q = dvd / dvs;
        r = dvd % dvs;
        return {1'b0, q[3:0], r[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int dvd, input int dvs);
        logic [8:0] e;
        e = ref_div(dvd, dvs);
        chk({tag, "_done"}, {8'd0, done}, 9'd1);
        chk({tag, "_busy"}, {8'd0, busy}, 9'd0);
        chk({tag, "_res"}, {div_by_zero, quotient, remainder}, e);
    endtask

    // single operation from IDLE: accept, 4 RUN edges, done, back to IDLE
    task automatic run_op(input string tag, input int dvd, input int dvs);
        start    = 1'b1;
        dividend = dvd[3:0];
        divisor  = dvs[3:0];
        tick();
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        for (int i = 1; i <= 4; i++) begin
            chk({tag, "_busy_run"}, {8'd0, busy}, 9'd1);
            chk({tag, "_nodone_run"}, {8'd0, done}, 9'd0);
            tick();
        end
        check_result(tag, dvd, dvs);
        tick();
        chk({tag, "_done_pulse"}, {8'd0, done}, 9'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        tick();
        tick();
        chk("reset_outputs", {busy, done, div_by_zero, quotient[2:0], remainder[2:0]}, 9'd0);
        chk("reset_q", {5'd0, quotient}, 9'd0);
        rst = 1'b0;
        tick();

        run_op("d13_3", 13, 3);
        run_op("d15_1", 15, 1);
        run_op("d15_15", 15, 15);
        run_op("d0_5", 0, 5);
        run_op("d4_9", 4, 9);
        run_op("d14_7", 14, 7);
        run_op("d7_0", 7, 0);
        run_op("d6_4", 6, 4);

        // start during RUN is ignored
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        tick();
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        tick();
        start = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            chk("ign_nodone", {8'd0, done}, 9'd0);
            tick();
        end
        check_result("ign_9_2", 9, 2);
        tick();
        chk("ign_single_done", {8'd0, done}, 9'd0);
        tick();
        chk("ign_idle_busy", {8'd0, busy}, 9'd0);

        // back-to-back with start held high
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 4; i++) begin
                chk("b2b_busy", {8'd0, busy}, 9'd1);
                chk("b2b_nodone", {8'd0, done}, 9'd0);
                tick();
            end
            check_result("b2b", 12, 5);
            tick();
        end
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check_result("b2b_last", 12, 5);
        tick();
        tick();

        // random operands
        for (int n = 0; n < 30; n++) begin
            int a;
            int b;
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            run_op("rand", a, b);
        end

        // reset in the 2nd RUN cycle discards the operation
        start = 1'b1; dividend = 4'd11; divisor = 4'd3;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs", {busy, done, div_by_zero, quotient[2:0], remainder[2:0]}, 9'd0);
        chk("rst_mid_qr", {1'b0, quotient, remainder}, 9'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_done", {7'd0, busy, done}, 9'd0);
        end
        run_op("d11_3", 11, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
